// File: rtl/npc_bus_pkg.sv
// ============================================================================
// Module      : npc_bus_pkg
// Description : Shared FSM encoding, word step and default parameters for the
//               npc request bus to memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_bus_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] C_WORD_STEP = 32'd4;
  localparam int DEF_MAX_OUT = 4;
  localparam int DEF_TO_CYC  = 1024;

  // Byte address of the following word; wraps mod 2^32.
  function automatic logic [31:0] next_word_adr(input logic [31:0] adr);
    return adr + C_WORD_STEP;
  endfunction
endpackage

`default_nettype wire

// File: rtl/npc_bus_wdt.sv
// ============================================================================
// Module      : npc_bus_wdt
// Description : Stall watchdog: counts cycles without progress while a
//               transfer is active, pulses o_timeout and sets sticky o_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_bus_wdt
  import npc_bus_pkg::*;
#(
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_progress,
  output logic o_timeout,
  output logic o_err
);
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_hit;

  // Fires on the TO_CYC-th consecutive stalled cycle.
  assign w_hit     = i_active && !i_progress && (r_cnt == CW'(TO_CYC - 1));
  assign o_timeout = w_hit;
  assign o_err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (!i_active || i_progress || w_hit) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + 1'b1;
      if (w_hit) r_err <= 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/npc_mem_bridge.sv
// ============================================================================
// Module      : npc_mem_bridge
// Description : npc request-bus slave converting one read/write burst into a
//               pipelined word-by-word memory port access.
//               Optional stall watchdog and npc_err port: NPC_BUS_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_mem_bridge
  import npc_bus_pkg::*;
#(
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int TO_CYC  = DEF_TO_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        npc_req,
  output logic        npc_gnt,
  input  logic        npc_rwn,
  input  logic [31:0] npc_adr,
  input  logic [31:0] npc_len,
  input  logic [31:0] npc_wdt,
  output logic [31:0] npc_rdt,
  output logic        npc_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdt,
  input  logic        mem_rdy,
  input  logic        mem_rvld,
  input  logic [31:0] mem_rdt
`ifdef NPC_BUS_WDT_EN
  ,output logic       npc_err
`endif
);
  logic [1:0]  r_state;
  logic [31:0] r_cur;
  logic [31:0] r_len;
  logic [31:0] r_cnt;
  logic [31:0] r_issued;
  logic [3:0]  r_out;
  logic        r_gnt;
  logic        r_rack;
  logic [31:0] r_rdt;

  logic w_is_wr, w_is_rd, w_rd_issue, w_mem_req, w_accept, w_rd_acc, w_ret, w_ack;
  logic w_timeout;

  assign w_is_wr    = (r_state == ST_WR);
  assign w_is_rd    = (r_state == ST_RD);
  assign w_rd_issue = w_is_rd && (r_issued != r_len) && (r_out < 4'(MAX_OUT));
  assign w_mem_req  = w_is_wr || w_rd_issue;
  assign w_accept   = w_mem_req && mem_rdy;
  assign w_rd_acc   = w_accept && w_is_rd;
  // A return only counts against a read still in flight; stray ones are dropped.
  assign w_ret      = w_is_rd && mem_rvld && (r_out != 4'd0);
  assign w_ack      = (w_is_wr && w_accept) || r_rack;

  assign npc_gnt = r_gnt;
  assign npc_ack = w_ack;
  assign npc_rdt = r_rdt;
  assign mem_req = w_mem_req;
  assign mem_we  = w_is_wr;
  assign mem_adr = w_mem_req ? r_cur : 32'd0;
  assign mem_wdt = w_is_wr ? npc_wdt : 32'd0;

`ifdef NPC_BUS_WDT_EN
  logic w_progress;
  assign w_progress = (w_mem_req && mem_rdy) || w_ret;

  npc_bus_wdt #(
    .TO_CYC(TO_CYC)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .i_active   (w_is_wr || w_is_rd),
    .i_progress (w_progress),
    .o_timeout  (w_timeout),
    .o_err      (npc_err)
  );
`else
  logic w_unused_to_cyc;
  assign w_timeout       = 1'b0;
  assign w_unused_to_cyc = (TO_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cur    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_issued <= '0;
      r_out    <= '0;
      r_gnt    <= 1'b0;
      r_rack   <= 1'b0;
      r_rdt    <= '0;
    end else begin
      r_gnt  <= 1'b0;
      r_rack <= w_ret;
      if (w_ret)    r_rdt    <= mem_rdt;
      if (w_accept) r_cur    <= next_word_adr(r_cur);
      if (w_rd_acc) r_issued <= r_issued + 32'd1;
      if (w_ack)    r_cnt    <= r_cnt + 32'd1;
      r_out <= r_out + {3'b000, w_rd_acc} - {3'b000, w_ret};

      case (r_state)
        ST_IDLE: begin
          if (npc_req) begin
            r_gnt    <= 1'b1;
            r_cur    <= npc_adr & ~32'd3;
            r_len    <= npc_len;
            r_cnt    <= '0;
            r_issued <= '0;
            r_out    <= '0;
            if (npc_len == 32'd0) r_state <= ST_DONE;
            else if (npc_rwn)     r_state <= ST_RD;
            else                  r_state <= ST_WR;
          end
        end
        ST_WR:   if (w_accept && (r_cnt + 32'd1 == r_len)) r_state <= ST_DONE;
        ST_RD:   if (r_rack && (r_cnt + 32'd1 == r_len))   r_state <= ST_DONE;
        default: if (!npc_req)                             r_state <= ST_IDLE;
      endcase

      if (w_timeout) r_state <= ST_DONE;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_npc_mem_bridge.sv
// ============================================================================
// Module      : tb_npc_mem_bridge
// Description : Self-checking bench for npc_mem_bridge: vector table plus
//               reset-abort and (with NPC_BUS_WDT_EN) watchdog sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_npc_mem_bridge;
  localparam int MAXO = 4;
  localparam int TOC  = 8;

  logic        clk, rst;
  logic        npc_req, npc_gnt, npc_rwn, npc_ack;
  logic [31:0] npc_adr, npc_len, npc_wdt, npc_rdt;
  logic        mem_req, mem_we, mem_rdy, mem_rvld;
  logic [31:0] mem_adr, mem_wdt, mem_rdt;
`ifdef NPC_BUS_WDT_EN
  logic        npc_err;
`endif

  npc_mem_bridge #(.MAX_OUT(MAXO), .TO_CYC(TOC)) dut (
    .clk(clk), .rst(rst),
    .npc_req(npc_req), .npc_gnt(npc_gnt), .npc_rwn(npc_rwn),
    .npc_adr(npc_adr), .npc_len(npc_len), .npc_wdt(npc_wdt),
    .npc_rdt(npc_rdt), .npc_ack(npc_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdt(mem_wdt),
    .mem_rdy(mem_rdy), .mem_rvld(mem_rvld), .mem_rdt(mem_rdt)
`ifdef NPC_BUS_WDT_EN
    ,.npc_err(npc_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] wdata(input int k);
    return 32'hA5C3_0000 ^ (32'(k) * 32'h0001_1111);
  endfunction

  // Memory read-return model: fixed latency from accept to mem_rvld.
  typedef struct { int due; logic [31:0] adr; } pend_t;
  pend_t pend[$];
  int cyc = 0;
  int lat = 1;

  initial begin
    mem_rvld = 1'b0;
    mem_rdt  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && mem_rdy && !mem_we) pend.push_back('{cyc + lat, mem_adr});
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rvld = 1'b1;
        mem_rdt  = rd_word(pend[0].adr);
        void'(pend.pop_front());
      end else begin
        mem_rvld = 1'b0;
        mem_rdt  = '0;
      end
    end
  end

  typedef struct {
    logic        rwn;
    logic [31:0] adr;
    logic [31:0] len;
    int          lat;
    logic [3:0]  rdy_pat;
    logic [31:0] exp_acks;
    logic [31:0] exp_last_adr;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] base, last_adr;
    logic [31:0] wq_adr[$];
    logic [31:0] wq_dat[$];
    logic [31:0] rq[$];
    int gnts, acks, acc, ret, maxout, tail, bad_req, extra, steps;
    base = v.adr & ~32'd3;
    last_adr = 32'hDEAD_BEEF;
    gnts = 0; acks = 0; acc = 0; ret = 0; maxout = 0; tail = 0; bad_req = 0; extra = 0; steps = 0;
    for (int k = 0; k < int'(v.len); k++) begin
      if (v.rwn) rq.push_back(rd_word(base + 32'(4 * k)));
      else begin
        wq_adr.push_back(base + 32'(4 * k));
        wq_dat.push_back(wdata(k));
      end
    end
    lat = v.lat;
    npc_rwn = v.rwn; npc_adr = v.adr; npc_len = v.len; npc_wdt = wdata(0);
    mem_rdy = v.rdy_pat[3];
    npc_req = 1'b1;
    while (tail < 4 && steps < 400) begin
      @(negedge clk);
      if (npc_gnt) gnts++;
      if (tail >= 1 && mem_req) bad_req++;
      if (mem_req && mem_rdy) begin
        last_adr = mem_adr;
        if (mem_we) begin
          if (wq_adr.size() > 0) begin
            check($sformatf("v%0d_wr_adr", id), mem_adr, wq_adr.pop_front());
            check($sformatf("v%0d_wr_dat", id), mem_wdt, wq_dat.pop_front());
          end else extra++;
        end else acc++;
      end
      if (mem_rvld) ret++;
      if (acc - ret > maxout) maxout = acc - ret;
      if (npc_ack) begin
        acks++;
        if (v.rwn) begin
          if (rq.size() > 0) check($sformatf("v%0d_rd_dat", id), npc_rdt, rq.pop_front());
          else extra++;
        end
      end
      if (gnts > 0 && acks == int'(v.len)) tail++;
      @(posedge clk);
      #1;
      mem_rdy = v.rdy_pat[steps % 4];
      npc_wdt = wdata(acks);
      steps++;
    end
    check($sformatf("v%0d_finished", id), 32'(steps < 400), 32'd1);
    check($sformatf("v%0d_gnt_pulses", id), 32'(gnts), 32'd1);
    check($sformatf("v%0d_acks", id), 32'(acks), v.exp_acks);
    check($sformatf("v%0d_last_adr", id), last_adr, v.exp_last_adr);
    check($sformatf("v%0d_left_expect", id), 32'(wq_adr.size() + rq.size() + extra), 32'd0);
    check($sformatf("v%0d_max_out_ok", id), 32'(maxout <= MAXO), 32'd1);
    check($sformatf("v%0d_req_after_done", id), 32'(bad_req), 32'd0);
    npc_req = 1'b0;
    mem_rdy = 1'b0;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (npc_gnt || npc_ack || mem_req) extra++;
      @(posedge clk);
      #1;
    end
    check($sformatf("v%0d_quiet_after_drop", id), 32'(extra), 32'd0);
  endtask

  initial begin
    rst = 1'b1; npc_req = 1'b0; npc_rwn = 1'b0; npc_adr = '0; npc_len = '0;
    npc_wdt = '0; mem_rdy = 1'b0;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'd3, 1, 4'b1111, 32'd3, 32'h0000_0108};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'd6, 3, 4'b1111, 32'd6, 32'h0000_0214};
    vecs[2] = '{1'b0, 32'h0000_0040, 32'd0, 1, 4'b1111, 32'd0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'hFFFF_FFF8, 32'd3, 1, 4'b1111, 32'd3, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h0000_0400, 32'd4, 3, 4'b1001, 32'd4, 32'h0000_040C};
    vecs[5] = '{1'b1, 32'h0000_0010, 32'd5, 1, 4'b1111, 32'd5, 32'h0000_0020};
    vecs[6] = '{1'b0, 32'h0000_0802, 32'd4, 1, 4'b0101, 32'd4, 32'h0000_080C};
    vecs[7] = '{1'b1, 32'h0000_1000, 32'd8, 7, 4'b1111, 32'd8, 32'h0000_101C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(npc_gnt), 32'd0);
    check("rst_ack", 32'(npc_ack), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_adr", mem_adr, 32'd0);
    check("rst_mem_wdt", mem_wdt, 32'd0);
    check("rst_rdt", npc_rdt, 32'd0);
`ifdef NPC_BUS_WDT_EN
    check("rst_err", 32'(npc_err), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset mid-read with two reads in flight; their late returns must be dropped.
    begin
      int acc2, acks2, rv2, nz, st;
      acc2 = 0; acks2 = 0; rv2 = 0; nz = 0; st = 0;
      lat = 8;
      npc_rwn = 1'b1; npc_adr = 32'h300; npc_len = 32'd4; mem_rdy = 1'b1; npc_req = 1'b1;
      while (acc2 < 2 && st < 20) begin
        @(negedge clk);
        if (mem_req && mem_rdy) acc2++;
        @(posedge clk);
        #1;
        st++;
      end
      check("rstmid_accepts", 32'(acc2), 32'd2);
      mem_rdy = 1'b0; rst = 1'b1; npc_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (14) begin
        @(negedge clk);
        if (npc_ack) acks2++;
        if (mem_rvld) rv2++;
        if (npc_gnt || mem_req || mem_we || mem_adr != 0 || mem_wdt != 0 || npc_rdt != 0) nz++;
        @(posedge clk);
        #1;
      end
      check("rstmid_no_ack", 32'(acks2), 32'd0);
      check("rstmid_returns_seen", 32'(rv2), 32'd2);
      check("rstmid_outputs_zero", 32'(nz), 32'd0);
    end

`ifdef NPC_BUS_WDT_EN
    // Stalled write: err appears after exactly TOC stalled cycles, no acks.
    begin
      int n, st, acks3;
      logic seen;
      n = 0; st = 0; acks3 = 0; seen = 1'b0;
      npc_rwn = 1'b0; npc_adr = 32'h500; npc_len = 32'd2; mem_rdy = 1'b0; npc_req = 1'b1;
      while (!seen && st < 40) begin
        @(negedge clk);
        if (npc_gnt) n = 1;
        else if (n > 0) n++;
        if (npc_ack) acks3++;
        if (npc_err) begin
          seen = 1'b1;
          check("wdt_err_cycle", 32'(n), 32'(TOC + 1));
          check("wdt_mem_req_dropped", 32'(mem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        st++;
      end
      check("wdt_err_seen", 32'(seen), 32'd1);
      check("wdt_no_ack", 32'(acks3), 32'd0);
      npc_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("wdt_err_sticky", 32'(npc_err), 32'd1);
      @(posedge clk);
      #1;
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

`default_nettype wire
